// File: rtl/ahblite_busmatrix_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahblite_busmatrix_rr_arbiter
//
// Registered four-requester arbiter for one AHB-lite bus matrix output stage.
// Selects which input stage drives the slave-side address/control muxes.
// Arbitration is round-robin or fixed-priority. The grant is held for the
// remaining beats of a defined-length burst.
//
// Ports:
//   HCLK                system clock, all state on rising edge
//   HRESETn             asynchronous active-low reset
//   REQ[3:0]            per-input-stage request (TRANS_HOLD & HSEL)
//   HREADY_Outputstage  output stage HREADY; state only advances when high
//   HSEL_Outputstage    HSEL currently driven by the output stage
//   HTRANS_Outputstage  HTRANS currently driven by the output stage
//   HBURST_Outputstage  HBURST currently driven by the output stage
//   PORT_SEL[1:0]       granted port index (registered)
//   PORT_NOSEL          1 = no port granted, output stage drives idle
//   LOCKED              1 = burst lock active (registered)
// ---------------------------------------------------------------------------
module ahblite_busmatrix_rr_arbiter #(
    parameter bit         RR_EN         = 1'b1,
    parameter logic [1:0] DEFAULT_PORT  = 2'd0,
    parameter bit         BURST_LOCK_EN = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [3:0] REQ,
    input  logic       HREADY_Outputstage,
    input  logic       HSEL_Outputstage,
    input  logic [1:0] HTRANS_Outputstage,
    input  logic [2:0] HBURST_Outputstage,
    output logic [1:0] PORT_SEL,
    output logic       PORT_NOSEL,
    output logic       LOCKED
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [3:0] beat_cnt;
    logic [3:0] next_cnt;
    logic [1:0] rr_ptr;
    logic [1:0] grant_idx;
    logic       grant_valid;

    // Remaining-beat count after this edge. A NONSEQ only loads when the port
    // presenting it already owns the bus (PORT_NOSEL low before the edge); at
    // a grant-changing edge the NONSEQ belongs to the outgoing master.
    always_comb begin
        next_cnt = beat_cnt;
        if (!HSEL_Outputstage) begin
            next_cnt = 4'd0;
        end else begin
            case (HTRANS_Outputstage)
                TRANS_IDLE: next_cnt = 4'd0;
                TRANS_BUSY: next_cnt = beat_cnt;
                TRANS_NONSEQ: begin
                    next_cnt = 4'd0;
                    if (BURST_LOCK_EN && !PORT_NOSEL) begin
                        case (HBURST_Outputstage)
                            3'b010, 3'b011: next_cnt = 4'd3;
                            3'b100, 3'b101: next_cnt = 4'd7;
                            3'b110, 3'b111: next_cnt = 4'd15;
                            default:        next_cnt = 4'd0;
                        endcase
                    end
                end
                TRANS_SEQ: begin
                    if (beat_cnt != 4'd0) begin
                        next_cnt = beat_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Winner selection. Loops scan from lowest priority to highest so the
    // last matching assignment is the winner. In round-robin mode the offset
    // wraps in 2 bits, giving the order ptr+1, ptr+2, ptr+3, ptr.
    always_comb begin
        grant_valid = |REQ;
        grant_idx   = rr_ptr;
        if (RR_EN) begin
            for (int k = 4; k >= 1; k--) begin
                if (REQ[rr_ptr + 2'(k)]) begin
                    grant_idx = rr_ptr + 2'(k);
                end
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (REQ[k]) begin
                    grant_idx = 2'(k);
                end
            end
        end
    end

    // Arbitration happens on the same edge that finishes or aborts a burst,
    // because it is gated by next_cnt rather than beat_cnt.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt   <= 4'd0;
            rr_ptr     <= DEFAULT_PORT;
            PORT_SEL   <= DEFAULT_PORT;
            PORT_NOSEL <= 1'b1;
            LOCKED     <= 1'b0;
        end else if (HREADY_Outputstage) begin
            beat_cnt <= next_cnt;
            LOCKED   <= (next_cnt != 4'd0);
            if (next_cnt == 4'd0) begin
                if (grant_valid) begin
                    PORT_SEL   <= grant_idx;
                    PORT_NOSEL <= 1'b0;
                    rr_ptr     <= grant_idx;
                end else begin
                    PORT_NOSEL <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ahblite_busmatrix_rr_arbiter.md
Name: ahblite_busmatrix_rr_arbiter

Overview:
- Four-requester arbiter for one AHB-lite bus matrix output stage (slave port).
- Each requester is a bus matrix input stage asserting REQ when it holds a pending transfer for this slave.
- Registered arbiter: issues a 2-bit port select plus a no-port flag, which drive the output-stage address/control muxes.
- Supports round-robin or fixed priority, and locks the grant for the length of defined-length bursts.

Parameters:
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (port 0 highest, port 3 lowest).
- DEFAULT_PORT, 2'd0, PORT_SEL value after reset, and initial round-robin pointer.
- BURST_LOCK_EN, 1, 1 = hold grant through defined-length bursts, 0 = re-arbitrate at every HREADY.

Ports:
- HCLK  input  1  system clock, all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- REQ  input  4  per-port request (REQ[n] = TRANS_HOLD & HSEL of input stage n).
- HREADY_Outputstage  input  1  HREADY of the output stage; arbitration and counter updates happen only when high.
- HSEL_Outputstage  input  1  HSEL currently driven by the output stage.
- HTRANS_Outputstage  input  2  HTRANS currently driven by the output stage.
- HBURST_Outputstage  input  3  HBURST currently driven by the output stage.
- PORT_SEL  output  2  granted port index (registered).
- PORT_NOSEL  output  1  1 = no port granted, output stage drives idle (registered).
- LOCKED  output  1  1 = burst lock active (registered, debug/verification visibility).

Behaviour:
Reset (HRESETn low, asynchronous):
- PORT_SEL = DEFAULT_PORT, PORT_NOSEL = 1, LOCKED = 0.
- Beat counter = 0, rr pointer (last granted) = DEFAULT_PORT.
- Reset asserted mid-burst drops the lock immediately.

Update rule:
- State updates only on a rising HCLK edge with HREADY_Outputstage = 1.
- With HREADY_Outputstage = 0, every register holds, regardless of REQ.
- Latency: a REQ seen at edge k is reflected on PORT_SEL/PORT_NOSEL after edge k (one cycle).

Beat counter (4 bits):
- Load on an accepted NONSEQ with HSEL_Outputstage = 1 and BURST_LOCK_EN = 1:
  - WRAP4/INCR4 (3'b010/3'b011) -> 3.
  - WRAP8/INCR8 (3'b100/3'b101) -> 7.
  - WRAP16/INCR16 (3'b110/3'b111) -> 15.
  - SINGLE/INCR (3'b000/3'b001) -> 0.
- Decrement on each accepted SEQ while the counter is nonzero.
- BUSY: counter holds.
- IDLE, or HSEL_Outputstage = 0, while nonzero: clear to 0 (early termination releases the lock).
- LOCKED is the registered (counter != 0) result of the same edge.

Arbitration (at an update edge):
- If the next counter value is nonzero: PORT_SEL and PORT_NOSEL hold, REQ is ignored.
- Otherwise:
  - REQ == 0: PORT_NOSEL = 1, PORT_SEL holds its last value (park).
  - RR_EN = 1: grant the first n with REQ[n] = 1, scanning circularly from pointer+1 (e.g. pointer = 2 -> order 3,0,1,2). The current holder therefore wins only if no other port requests. Pointer = granted n.
  - RR_EN = 0: grant the lowest-index n with REQ[n] = 1.
  - On a grant, PORT_NOSEL = 0.
- A request deasserting while its port is granted and unlocked: re-arbitrate at the next update edge.
- A request deasserting during a lock: it is ignored until the lock ends.
- Simultaneous burst completion (final SEQ accepted) and a new request: the counter reaches 0 on that edge, and arbitration occurs on the same edge.
- A new NONSEQ at a grant-changing edge belongs to the outgoing master's address phase. The counter loads only when the NONSEQ is presented by the port already granted (PORT_NOSEL = 0 before the edge).

Test Plan:
- Reset with REQ = 4'b1111 held -> PORT_NOSEL = 1, PORT_SEL = 0 during reset. After release, the first edge (RR_EN = 1, pointer 0) gives PORT_SEL = 1, PORT_NOSEL = 0.
- REQ = 4'b1111, all SINGLE, HREADY = 1 -> PORT_SEL sequence 1,2,3,0,1 on successive edges. With RR_EN = 0: PORT_SEL stays 0.
- Port 2 granted, NONSEQ INCR4, then 3 SEQ while REQ[0] = 1 -> PORT_SEL = 2 and LOCKED = 1 for 4 transfers. PORT_SEL = 0 on the edge accepting the final SEQ.
- INCR8 locked, master drives IDLE after 3 beats -> LOCKED = 0 on the next edge, other requester granted the same edge.
- HREADY_Outputstage held 0 for 5 cycles while REQ changes 4'b0001 -> 4'b1000 -> PORT_SEL/PORT_NOSEL/counter unchanged. Update occurs on the first edge with HREADY = 1.
- REQ drops to 0 with PORT_SEL = 3 -> PORT_NOSEL = 1, PORT_SEL stays 3. HRESETn pulsed low mid-INCR16 -> LOCKED = 0 and PORT_SEL = DEFAULT_PORT immediately, asynchronously.
